// File: rtl/lsu_req_stage.sv
// rtl/lsu_req_stage.sv - EX->MEM load/store request stage (optional MISALIGN_TRAP_EN)
package lsu_req_stage_pkg;
  typedef struct packed {
    logic       reg_write;
    logic [4:0] rd;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } control_type;
endpackage

module lsu_req_stage
  import lsu_req_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  input  logic [31:0]       alu_data_in,
  input  logic [31:0]       memory_data_in,
  input  control_type       control_in,
  output logic              ram_d_req,
  input  logic              ram_d_gnt,
  output logic              ram_d_we,
  output logic [3:0]        ram_d_be,
  output logic [ADDR_W-1:0] ram_d_addr,
  output logic [31:0]       ram_d_wdata,
  input  logic              ram_d_rvalid,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       alu_data_out,
  output logic [31:0]       memory_data_out,
  output control_type       control_out,
  output logic              misalign_out
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] FULL = 2'd3;

  logic [1:0]  state;
  logic        discard_q;
  logic        accept;
  logic        is_mem;
  logic        trap_d;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && (state == IDLE) && !flush;
  assign is_mem   = control_in.mem_read | control_in.mem_write;

  // Byte lanes come from the low address bits; loads always fetch the whole word.
  always_comb begin
    be_d    = 4'hF;
    wdata_d = memory_data_in;
    if (control_in.mem_write) begin
      case (control_in.funct3[1:0])
        2'b00: begin
          be_d    = 4'b0001 << alu_data_in[1:0];
          wdata_d = {4{memory_data_in[7:0]}};
        end
        2'b01: begin
          be_d    = 4'b0011 << {alu_data_in[1], 1'b0};
          wdata_d = {2{memory_data_in[15:0]}};
        end
        default: begin
          be_d    = 4'hF;
          wdata_d = memory_data_in;
        end
      endcase
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  always_comb begin
    case (control_in.funct3[1:0])
      2'b00:   trap_d = 1'b0;
      2'b01:   trap_d = is_mem & alu_data_in[0];
      default: trap_d = is_mem & (alu_data_in[1:0] != 2'b00);
    endcase
  end

  assign misalign_out = misalign_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= trap_d;
    end
  end
`else
  assign trap_d       = 1'b0;
  assign misalign_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= IDLE;
      discard_q       <= 1'b0;
      ram_d_req       <= 1'b0;
      ram_d_we        <= 1'b0;
      ram_d_be        <= 4'h0;
      ram_d_addr      <= '0;
      ram_d_wdata     <= 32'h0;
      out_valid       <= 1'b0;
      alu_data_out    <= 32'h0;
      memory_data_out <= 32'h0;
      control_out     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_data_out    <= alu_data_in;
            memory_data_out <= memory_data_in;
            control_out     <= control_in;
            discard_q       <= 1'b0;
            if (!is_mem || trap_d) begin
              state     <= FULL;
              out_valid <= 1'b1;
            end else begin
              state       <= REQ;
              ram_d_req   <= 1'b1;
              ram_d_we    <= control_in.mem_write;
              ram_d_be    <= be_d;
              ram_d_addr  <= ADDR_W'({alu_data_in[31:2], 2'b00});
              ram_d_wdata <= wdata_d;
            end
          end
        end
        REQ: begin
          // A flushed request stays up until granted; only its result is dropped.
          if (flush) begin
            discard_q <= 1'b1;
          end
          if (ram_d_gnt) begin
            ram_d_req <= 1'b0;
            if (!ram_d_we) begin
              state <= WAIT;
            end else if (discard_q || flush) begin
              state <= IDLE;
            end else begin
              state     <= FULL;
              out_valid <= 1'b1;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            discard_q <= 1'b1;
          end
          if (ram_d_rvalid) begin
            if (discard_q || flush) begin
              state <= IDLE;
            end else begin
              state     <= FULL;
              out_valid <= 1'b1;
            end
          end
        end
        default: begin
          if (flush || out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_req_stage.sv
// tb/tb_lsu_req_stage.sv - directed + randomized self-checking bench for lsu_req_stage
module tb_lsu_req_stage;
    import lsu_req_stage_pkg::*;

`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic [31:0] alu_in = 32'h0;
    logic [31:0] mem_in = 32'h0;
    control_type ctrl_in = '0;
    logic        ram_d_req;
    logic        ram_d_gnt = 1'b0;
    logic        ram_d_we;
    logic [3:0]  ram_d_be;
    logic [31:0] ram_d_addr;
    logic [31:0] ram_d_wdata;
    logic        ram_d_rvalid = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] alu_out;
    logic [31:0] mem_out;
    control_type ctrl_out;
    logic        misalign_out;

    int n_assert = 0;
    int n_fail   = 0;

    lsu_req_stage #(.ADDR_W(32)) dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .alu_data_in(alu_in), .memory_data_in(mem_in), .control_in(ctrl_in),
        .ram_d_req(ram_d_req), .ram_d_gnt(ram_d_gnt), .ram_d_we(ram_d_we), .ram_d_be(ram_d_be),
        .ram_d_addr(ram_d_addr), .ram_d_wdata(ram_d_wdata), .ram_d_rvalid(ram_d_rvalid),
        .out_valid(out_valid), .out_ready(out_ready), .alu_data_out(alu_out),
        .memory_data_out(mem_out), .control_out(ctrl_out), .misalign_out(misalign_out)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic control_type mk(input bit rd_en, input bit wr_en, input logic [2:0] f3);
        control_type c;
        c.reg_write = rd_en | ~wr_en;
        c.rd        = 5'd7;
        c.mem_read  = rd_en;
        c.mem_write = wr_en;
        c.funct3    = f3;
        return c;
    endfunction

    function automatic logic [3:0] exp_be(input control_type c, input logic [31:0] a);
        int sz = int'(c.funct3[1:0]);
        if (!c.mem_write) return 4'hF;
        if (sz == 0) return 4'(1 << (a % 4));
        if (sz == 1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input control_type c, input logic [31:0] d);
        int sz = int'(c.funct3[1:0]);
        if (!c.mem_write) return d;
        if (sz == 0) return 32'(d % 256) * 32'h01010101;
        if (sz == 1) return 32'(d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic bit exp_mis(input control_type c, input logic [31:0] a);
        int sz = int'(c.funct3[1:0]);
        if (!(c.mem_read || c.mem_write)) return 1'b0;
        if (sz == 1) return (a % 2) != 0;
        if (sz >= 2) return (a % 4) != 0;
        return 1'b0;
    endfunction

    task automatic accept_op(input logic [31:0] a, input logic [31:0] d, input control_type c);
        in_valid = 1'b1;
        alu_in   = a;
        mem_in   = d;
        ctrl_in  = c;
        tick();
        in_valid = 1'b0;
        alu_in   = $urandom;
        mem_in   = $urandom;
        ctrl_in  = mk(1'b1, 1'b1, 3'b111);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] d, input control_type c,
                          input int gd, input int rd, input int hold);
        bit is_mem = c.mem_read | c.mem_write;
        bit trap   = TRAP && exp_mis(c, a);
        check("idle_in_ready", 64'(in_ready), 64'(1'b1));
        out_ready = 1'b0;
        accept_op(a, d, c);
        if (is_mem && !trap) begin
            for (int i = 0; i <= gd; i++) begin
                check("req_held", 64'(ram_d_req), 64'(1'b1));
                check("req_addr", 64'(ram_d_addr), 64'(a & 32'hFFFF_FFFC));
                check("req_be", 64'(ram_d_be), 64'(exp_be(c, a)));
                check("req_we", 64'(ram_d_we), 64'(c.mem_write));
                if (c.mem_write) check("req_wdata", 64'(ram_d_wdata), 64'(exp_wdata(c, d)));
                check("req_in_ready", 64'(in_ready), 64'(1'b0));
                check("req_no_valid", 64'(out_valid), 64'(1'b0));
                ram_d_gnt = (i == gd);
                tick();
            end
            ram_d_gnt = 1'b0;
            check("req_dropped", 64'(ram_d_req), 64'(1'b0));
            if (!c.mem_write) begin
                for (int i = 0; i <= rd; i++) begin
                    check("wait_no_valid", 64'(out_valid), 64'(1'b0));
                    ram_d_rvalid = (i == rd);
                    tick();
                end
                ram_d_rvalid = 1'b0;
            end
        end
        for (int i = 0; i <= hold; i++) begin
            check("full_valid", 64'(out_valid), 64'(1'b1));
            check("full_alu", 64'(alu_out), 64'(a));
            check("full_mdata", 64'(mem_out), 64'(d));
            check("full_ctrl", 64'(ctrl_out), 64'(c));
            check("full_misalign", 64'(misalign_out), 64'(trap));
            check("full_in_ready", 64'(in_ready), 64'(1'b0));
            check("full_no_req", 64'(ram_d_req), 64'(1'b0));
            out_ready = (i == hold);
            tick();
        end
        out_ready = 1'b0;
        check("released_valid", 64'(out_valid), 64'(1'b0));
        check("released_in_ready", 64'(in_ready), 64'(1'b1));
    endtask

    initial begin
        tick();
        tick();
        check("rst_req", 64'(ram_d_req), 64'(1'b0));
        check("rst_we", 64'(ram_d_we), 64'(1'b0));
        check("rst_be", 64'(ram_d_be), 64'(4'h0));
        check("rst_addr", 64'(ram_d_addr), 64'(32'h0));
        check("rst_wdata", 64'(ram_d_wdata), 64'(32'h0));
        check("rst_valid", 64'(out_valid), 64'(1'b0));
        check("rst_alu", 64'(alu_out), 64'(32'h0));
        check("rst_mdata", 64'(mem_out), 64'(32'h0));
        check("rst_ctrl", 64'(ctrl_out), 64'(11'h0));
        check("rst_misalign", 64'(misalign_out), 64'(1'b0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        reset_n = 1'b1;
        tick();

        run_op(32'h1234_5678, 32'h0BAD_F00D, mk(1'b0, 1'b0, 3'b000), 0, 0, 0);
        run_op(32'h0000_1003, 32'h0000_00AB, mk(1'b0, 1'b1, 3'b000), 3, 0, 0);
        check("sb_literal_wdata_kept", 64'(ram_d_wdata), 64'(32'hABAB_ABAB));
        check("sb_literal_be_kept", 64'(ram_d_be), 64'(4'b1000));
        run_op(32'h0000_2000, 32'h0, mk(1'b1, 1'b0, 3'b010), 0, 1, 0);
        run_op(32'h0000_4008, 32'hCAFE_BABE, mk(1'b0, 1'b1, 3'b010), 1, 0, 5);
        run_op(32'h0000_3002, 32'h1122_3344, mk(1'b0, 1'b1, 3'b001), 0, 0, 0);

        run_op(32'h0000_3001, 32'h0, mk(1'b1, 1'b0, 3'b001), 0, 0, 0);
        run_op(32'h0000_3001, 32'h0000_BEEF, mk(1'b0, 1'b1, 3'b001), 0, 0, 0);

        accept_op(32'h0000_5000, 32'h0, mk(1'b1, 1'b0, 3'b010));
        ram_d_gnt = 1'b1;
        ram_d_rvalid = 1'b1;
        tick();
        ram_d_gnt = 1'b0;
        ram_d_rvalid = 1'b0;
        tick();
        check("early_rvalid_ignored", 64'(out_valid), 64'(1'b0));
        ram_d_rvalid = 1'b1;
        tick();
        ram_d_rvalid = 1'b0;
        check("late_rvalid_done", 64'(out_valid), 64'(1'b1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        accept_op(32'h0000_2000, 32'h0, mk(1'b1, 1'b0, 3'b010));
        ram_d_gnt = 1'b1;
        tick();
        ram_d_gnt = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("wait_flush_still_busy", 64'(in_ready), 64'(1'b0));
        ram_d_rvalid = 1'b1;
        tick();
        ram_d_rvalid = 1'b0;
        check("wait_flush_no_valid", 64'(out_valid), 64'(1'b0));
        check("wait_flush_idle", 64'(in_ready), 64'(1'b1));
        tick();
        check("wait_flush_no_valid_later", 64'(out_valid), 64'(1'b0));

        accept_op(32'h0000_6001, 32'h55, mk(1'b0, 1'b1, 3'b000));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("req_flush_held", 64'(ram_d_req), 64'(1'b1));
        tick();
        check("req_flush_held2", 64'(ram_d_req), 64'(1'b1));
        ram_d_gnt = 1'b1;
        tick();
        ram_d_gnt = 1'b0;
        check("req_flush_dropped", 64'(ram_d_req), 64'(1'b0));
        check("req_flush_no_valid", 64'(out_valid), 64'(1'b0));
        check("req_flush_idle", 64'(in_ready), 64'(1'b1));

        accept_op(32'h0000_7000, 32'h0, mk(1'b1, 1'b0, 3'b010));
        flush = 1'b1;
        ram_d_gnt = 1'b1;
        tick();
        flush = 1'b0;
        ram_d_gnt = 1'b0;
        check("req_flush_ld_waiting", 64'(in_ready), 64'(1'b0));
        ram_d_rvalid = 1'b1;
        tick();
        ram_d_rvalid = 1'b0;
        check("req_flush_ld_no_valid", 64'(out_valid), 64'(1'b0));
        check("req_flush_ld_idle", 64'(in_ready), 64'(1'b1));

        accept_op(32'h0000_0042, 32'h0, mk(1'b0, 1'b0, 3'b000));
        check("full_before_flush", 64'(out_valid), 64'(1'b1));
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("full_flush_valid", 64'(out_valid), 64'(1'b0));
        check("full_flush_idle", 64'(in_ready), 64'(1'b1));

        in_valid = 1'b1;
        flush = 1'b1;
        alu_in = 32'h0000_8000;
        ctrl_in = mk(1'b0, 1'b1, 3'b010);
        tick();
        in_valid = 1'b0;
        flush = 1'b0;
        check("idle_flush_in_ready", 64'(in_ready), 64'(1'b1));
        check("idle_flush_no_req", 64'(ram_d_req), 64'(1'b0));
        check("idle_flush_no_valid", 64'(out_valid), 64'(1'b0));

        accept_op(32'h0000_9000, 32'h77, mk(1'b0, 1'b1, 3'b010));
        check("pre_reset_req", 64'(ram_d_req), 64'(1'b1));
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_req", 64'(ram_d_req), 64'(1'b0));
        check("async_reset_in_ready", 64'(in_ready), 64'(1'b1));
        tick();
        reset_n = 1'b1;
        tick();

        for (int n = 0; n < 60; n++) begin
            int kind = int'($urandom_range(0, 2));
            logic [31:0] a = $urandom;
            logic [31:0] d = $urandom;
            logic [2:0] f3 = 3'($urandom_range(0, 2)) | (kind == 1 ? 3'($urandom_range(0, 1)) << 2 : 3'b000);
            control_type c = mk(kind == 1, kind == 2, f3);
            run_op(a, d, c, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                   int'($urandom_range(0, 2)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
